// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - per-button press/release/long/repeat classifier with round-robin event port
// Optional auto-repeat in LONG is enabled by defining AUTO_REPEAT_EN.
module btn_event_ctrl #(
  parameter int N_BTN    = 4,
  parameter int LONG_CNT = 8,
  parameter int REP_CNT  = 4,
  localparam int ID_W    = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_db,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic [N_BTN-1:0] ovf
);

  localparam int CNT_MAX = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
`ifdef AUTO_REPEAT_EN
  localparam logic [1:0] EV_REPEAT  = 2'b11;
`endif

  typedef enum logic [1:0] {ST_UP, ST_DOWN, ST_LONG} state_e;

  logic [N_BTN-1:0] prev_q;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] raise;
  logic [1:0]       raise_type [N_BTN];
  logic [N_BTN-1:0] slot_v_q, slot_v_d;
  logic [1:0]       slot_t_q [N_BTN];
  logic [1:0]       slot_t_d [N_BTN];
  logic [N_BTN-1:0] ovf_q, ovf_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [1:0]       evt_type_q, evt_type_d;

  logic [N_BTN-1:0] rise, fall;
  logic             out_free;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [N_BTN-1:0] grant_vec;

  assign rise     = btn_db & ~prev_q;
  assign fall     = ~btn_db & prev_q;
  assign out_free = !evt_valid_q || evt_ready;

  // Release is checked first in every pressed state so it beats a coincident threshold.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      raise[i]      = 1'b0;
      raise_type[i] = EV_PRESS;
      case (state_q[i])
        ST_UP: begin
          if (rise[i]) begin
            state_d[i]    = ST_DOWN;
            cnt_d[i]      = '0;
            raise[i]      = 1'b1;
            raise_type[i] = EV_PRESS;
          end
        end
        ST_DOWN: begin
          if (fall[i]) begin
            state_d[i]    = ST_UP;
            raise[i]      = 1'b1;
            raise_type[i] = EV_RELEASE;
          end else if (cnt_q[i] == CNT_W'(LONG_CNT - 1)) begin
            state_d[i]    = ST_LONG;
            cnt_d[i]      = '0;
            raise[i]      = 1'b1;
            raise_type[i] = EV_LONG;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_LONG: begin
          if (fall[i]) begin
            state_d[i]    = ST_UP;
            raise[i]      = 1'b1;
            raise_type[i] = EV_RELEASE;
          end
`ifdef AUTO_REPEAT_EN
          else if (cnt_q[i] == CNT_W'(REP_CNT - 1)) begin
            cnt_d[i]      = '0;
            raise[i]      = 1'b1;
            raise_type[i] = EV_REPEAT;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
`endif
        end
        default: state_d[i] = ST_UP;
      endcase
    end
  end

  // Round-robin scan starting at the pointer, wrapping mod N_BTN.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_BTN; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!grant_found && slot_v_q[j]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(j);
      end
    end
    grant_vec = (out_free && grant_found) ? (N_BTN'(1) << grant_id) : '0;
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      slot_v_d[i] = slot_v_q[i];
      slot_t_d[i] = slot_t_q[i];
      ovf_d[i]    = ovf_q[i];
      if (raise[i]) begin
        if (!slot_v_q[i] || grant_vec[i]) begin
          slot_v_d[i] = 1'b1;
          slot_t_d[i] = raise_type[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end else if (grant_vec[i]) begin
        slot_v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    ptr_d       = ptr_q;
    if (out_free) begin
      if (grant_found) begin
        evt_valid_d = 1'b1;
        evt_id_d    = grant_id;
        evt_type_d  = slot_t_q[grant_id];
        ptr_d       = (grant_id == ID_W'(N_BTN - 1)) ? '0 : grant_id + ID_W'(1);
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= '0;
      slot_v_q    <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= EV_PRESS;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]  <= ST_UP;
        cnt_q[i]    <= '0;
        slot_t_q[i] <= EV_PRESS;
      end
    end else begin
      prev_q      <= btn_db;
      slot_v_q    <= slot_v_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        slot_t_q[i] <= slot_t_d[i];
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_type  = evt_type_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - scoreboard bench for btn_event_ctrl
module tb_btn_event_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] btn_db;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic [3:0] ovf;

  int checks;
  int failures;

  logic [3:0] exp_q[$];

  btn_event_ctrl #(.N_BTN(4), .LONG_CNT(8), .REP_CNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_db    (btn_db),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [1:0] t);
    exp_q.push_back({id, t});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 200;
    while ((exp_q.size() != 0 || evt_valid) && budget > 0) begin
      tick(1);
      budget--;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=id%0d/t%0d expected=none", evt_id, evt_type);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("event", {28'd0, evt_id, evt_type}, {28'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    btn_db    = 4'b0000;
    evt_ready = 1'b1;

    // reset and idle
    tick(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_type", evt_type, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_valid", evt_valid, 0);
    end

    // short press on button 2
    push(2'd2, 2'b00);
    push(2'd2, 2'b01);
    btn_db = 4'b0100;
    tick(3);
    btn_db = 4'b0000;
    drain("short2");

    // 20-cycle hold on button 1
    push(2'd1, 2'b00);
    push(2'd1, 2'b10);
`ifdef AUTO_REPEAT_EN
    push(2'd1, 2'b11);
    push(2'd1, 2'b11);
`endif
    push(2'd1, 2'b01);
    btn_db = 4'b0010;
    tick(20);
    btn_db = 4'b0000;
    drain("hold1");

    // fresh reset so the pointer starts at 0, then simultaneous 0/3
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    push(2'd0, 2'b00);
    push(2'd3, 2'b00);
    btn_db = 4'b1001;
    tick(2);
    chk("rr_first_id", evt_id, 0);
    tick(1);
    chk("rr_second_id", evt_id, 3);
    tick(2);
    push(2'd0, 2'b01);
    push(2'd3, 2'b01);
    btn_db = 4'b0000;
    drain("rr");

    // backpressure: release held in slot, second press dropped
    evt_ready = 1'b0;
    btn_db    = 4'b0010;
    push(2'd1, 2'b00);
    tick(2);
    chk("bp_valid", evt_valid, 1);
    chk("bp_id", evt_id, 1);
    chk("bp_type", evt_type, 0);
    btn_db = 4'b0000;
    push(2'd1, 2'b01);
    tick(1);
    btn_db = 4'b0010;
    tick(2);
    chk("bp_hold_valid", evt_valid, 1);
    chk("bp_hold_id", evt_id, 1);
    chk("bp_hold_type", evt_type, 0);
    chk("bp_ovf", ovf, 4'b0010);
    push(2'd1, 2'b01);
    evt_ready = 1'b1;
    btn_db    = 4'b0000;
    drain("bp");
    chk("ovf_sticky", ovf, 4'b0010);

    // reset mid-stream while a long event is held on the output
    btn_db = 4'b0001;
    push(2'd0, 2'b00);
    tick(3);
    evt_ready = 1'b0;
    tick(8);
    chk("long_valid", evt_valid, 1);
    chk("long_id", evt_id, 0);
    chk("long_type", evt_type, 2'b10);
    chk("long_q_empty", exp_q.size(), 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", evt_valid, 0);
    chk("async_type", evt_type, 0);
    chk("async_ovf", ovf, 0);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    push(2'd0, 2'b00);
    rst = 1'b1;
    tick(2);
    chk("fresh_valid", evt_valid, 1);
    chk("fresh_id", evt_id, 0);
    chk("fresh_type", evt_type, 0);
    tick(1);
    push(2'd0, 2'b01);
    btn_db = 4'b0000;
    drain("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Controller behind the per-button debounce instances. It takes N_BTN debounced button levels and classifies each one with its own state machine into press, release, long-press and optional auto-repeat events. Events are buffered one slot per button and shared round-robin onto a single registered event port with a valid/ready handshake. The UI and game logic consume that port instead of raw levels.

Parameters:
N_BTN, 4, number of debounced button inputs (>=2)
LONG_CNT, 8, cycles a button must stay high after its press is captured before a long event (>=2)
REP_CNT, 4, cycles between repeat events while in LONG (>=2; used only with AUTO_REPEAT_EN)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
btn_db  in  N_BTN  debounced button levels, already synchronous to clk
evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a rising edge
evt_valid  out  1  event present on evt_id/evt_type
evt_id  out  max(1,$clog2(N_BTN))  index of the source button
evt_type  out  2  event code: 00 press, 01 release, 10 long, 11 repeat
ovf  out  N_BTN  sticky per-button flag, set when an event is dropped

Behaviour:
- Reset (rst=0, async): evt_valid=0, evt_id=0, evt_type=00, ovf=0, prev levels=0, all FSMs UP, counters=0, slots empty, round-robin pointer=0.
- Edge detection: rise = btn_db & ~prev, fall = ~btn_db & prev. prev is registered every cycle. A button high at reset release is a press on the first edge.
- Per-button FSM, counter width $clog2(max(LONG_CNT,REP_CNT)):
  - UP: on rise, go to DOWN, cnt<=0, raise press.
  - DOWN: on fall, go to UP, raise release. Else if cnt==LONG_CNT-1, go to LONG, cnt<=0, raise long. Else cnt++.
  - LONG: on fall, go to UP, raise release. Else see AUTO_REPEAT_EN.
  - Fall and threshold in the same cycle: release wins; no long or repeat is raised.
- Rise sampled at edge k: press is written to the slot at edge k, and long is raised at edge k+LONG_CNT.
- Event slot, one per button, holding a valid bit and a type:
  - A raised event loads the slot if it is empty, or if it is emptied by a grant in the same cycle.
  - Otherwise the new event is dropped and ovf[i] <= 1. The old slot content is kept.
- Output stage:
  - Free when !evt_valid or (evt_valid && evt_ready).
  - When free, the arbiter scans slots starting at the pointer and wrapping mod N_BTN. The first valid slot is granted, copied into evt_id/evt_type with evt_valid<=1 on the next edge, and cleared.
  - After a grant, the pointer <= granted id+1 mod N_BTN.
  - When free with no pending slot, evt_valid <= 0.
  - While evt_valid && !evt_ready, evt_id and evt_type stay stable.
- Throughput: one event per cycle when evt_ready stays 1.
- Latency: rise sampled at edge k with the output idle gives evt_valid=1 after edge k+1.
- ovf bits clear only on reset.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in LONG with the button still high, if cnt==REP_CNT-1 then cnt<=0 and raise repeat (11); else cnt++. The first repeat comes at edge k+LONG_CNT+REP_CNT.
- Undefined: LONG holds silently until fall, type 11 is never produced, and REP_CNT is unused.

Test Plan:
- Hold rst=0 for 3 cycles with btn_db=0, then release and idle 10 cycles -> all outputs 0 throughout and evt_valid never asserts.
- Defaults, evt_ready=1; btn_db[2] high for 3 cycles then low -> (id2,00), then (id2,01); no type 10.
- Defaults with AUTO_REPEAT_EN, evt_ready=1; btn_db[1] high for 20 cycles starting at edge k -> press, long at k+8, repeats at k+12 and k+16, then release. Without the macro -> press, long, release only.
- Defaults, evt_ready=1; btn_db[0] and btn_db[3] rise together -> (id0,00) then (id3,00) on consecutive cycles. Both fall 5 cycles later -> (id0,01) then (id3,01), since the pointer wrapped to 0.
- evt_ready=0 with (id1,00) held on the output; btn1 falls and then rises again while ready stays 0 -> output stable, release held in slot 1, second press dropped, ovf[1]=1. Raise ready -> (id1,01) follows.
- Assert rst mid-stream while evt_valid=1 and btn0 is in LONG -> outputs 0 immediately, before any clock. Deassert with btn_db[0] still high -> fresh (id0,00) after 2 edges.
